writeback_stage: RTL and testbench

WRITEBACK_STAGE -- requirements
Module: writeback_stage

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/wb_mux.sv | 22 ++
 rtl/writeback_stage.sv | 141 ++++++++++++++
 tb/tb_writeback_stage.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, writeback source encodings and
// the writeback FSM state constants.
package cpu_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC  = 2'b10,
        WB_RSV = 2'b11
    } wb_sel_e;

    typedef logic [1:0] wb_state_t;

    localparam wb_state_t ST_IDLE     = 2'd0;
    localparam wb_state_t ST_WAIT_MEM = 2'd1;
    localparam wb_state_t ST_COMMIT   = 2'd2;

endpackage

// File: rtl/wb_mux.sv
// Writeback source selector: picks the register-file write data from the
// latched ALU, load and PC+1 values.
module wb_mux #(
    parameter int DATA_W = cpu_pkg::DATA_W
) (
    input  cpu_pkg::wb_sel_e    sel,
    input  logic [DATA_W-1:0]   alu_result,
    input  logic [DATA_W-1:0]   mem_data,
    input  logic [DATA_W-1:0]   pc_plus1,
    output logic [DATA_W-1:0]   data
);
    import cpu_pkg::*;

    always_comb begin
        case (sel)
            WB_MEM:  data = mem_data;
            WB_PC:   data = pc_plus1;
            default: data = alu_result;   // reserved encoding behaves as ALU
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Pipeline writeback stage: accepts memory-stage results, waits for load data,
// and drives the register-file write port. Optional RETIRE_CNT_EN adds a retire counter.
module writeback_stage #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic              in_reg_write,
    input  logic [1:0]        in_wb_sel,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_pc_plus1,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              flush,
    output logic              write_enable,
    output logic [ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0] write_data,
    output logic [15:0]       retire_count
);
    import cpu_pkg::*;

    wb_state_t         state_q, state_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic              reg_write_q, reg_write_d;
    wb_sel_e           wb_sel_q, wb_sel_d;
    logic [DATA_W-1:0] alu_q, alu_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic [ADDR_W-1:0] last_reg_q, last_reg_d;
    logic [DATA_W-1:0] last_data_q, last_data_d;
    logic [DATA_W-1:0] mux_data;
    logic              accept;
    logic              commit;

    assign in_ready = !reset && !flush && (state_q != ST_WAIT_MEM);
    assign accept   = in_valid && in_ready;
    assign commit   = (state_q == ST_COMMIT);

    wb_mux #(.DATA_W(DATA_W)) u_wb_mux (
        .sel        (wb_sel_q),
        .alu_result (alu_q),
        .mem_data   (mem_data_q),
        .pc_plus1   (pc_q),
        .data       (mux_data)
    );

    always_comb begin
        state_d     = state_q;
        rd_d        = rd_q;
        reg_write_d = reg_write_q;
        wb_sel_d    = wb_sel_q;
        alu_d       = alu_q;
        pc_d        = pc_q;
        mem_data_d  = mem_data_q;
        case (state_q)
            ST_WAIT_MEM: begin
                // flush has priority over a load return in the same cycle
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (mem_ack) begin
                    mem_data_d = mem_rdata;
                    state_d    = ST_COMMIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                if (accept) begin
                    rd_d        = in_rd;
                    reg_write_d = in_reg_write;
                    wb_sel_d    = wb_sel_e'(in_wb_sel);
                    alu_d       = in_alu_result;
                    pc_d        = in_pc_plus1;
                    state_d     = (wb_sel_e'(in_wb_sel) == WB_MEM) ? ST_WAIT_MEM : ST_COMMIT;
                end
            end
        endcase
    end

    // Write address/data hold their last committed values between commits.
    assign last_reg_d  = commit ? rd_q : last_reg_q;
    assign last_data_d = commit ? mux_data : last_data_q;

    always_comb begin
        write_enable = 1'b0;
        write_reg    = '0;
        write_data   = '0;
        if (!reset) begin
            write_enable = commit && reg_write_q;
            write_reg    = commit ? rd_q : last_reg_q;
            write_data   = commit ? mux_data : last_data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            wb_sel_q    <= WB_ALU;
            alu_q       <= '0;
            pc_q        <= '0;
            mem_data_q  <= '0;
            last_reg_q  <= '0;
            last_data_q <= '0;
        end else begin
            state_q     <= state_d;
            rd_q        <= rd_d;
            reg_write_q <= reg_write_d;
            wb_sel_q    <= wb_sel_d;
            alu_q       <= alu_d;
            pc_q        <= pc_d;
            mem_data_q  <= mem_data_d;
            last_reg_q  <= last_reg_d;
            last_data_q <= last_data_d;
        end
    end

`ifdef RETIRE_CNT_EN
    logic [15:0] retire_cnt_q, retire_cnt_d;

    // Every commit retires an instruction, whether or not it writes a register.
    assign retire_cnt_d = commit ? retire_cnt_q + 16'd1 : retire_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            retire_cnt_q <= '0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign retire_count = reset ? 16'd0 : retire_cnt_q;
`else
    assign retire_count = 16'd0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios plus randomized
// traffic compared against a transaction-level reference model.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_rd;
    logic        in_reg_write;
    logic [1:0]  in_wb_sel;
    logic [15:0] in_alu_result;
    logic [15:0] in_pc_plus1;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        flush;
    logic        write_enable;
    logic [3:0]  write_reg;
    logic [15:0] write_data;
    logic [15:0] retire_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    writeback_stage #(.DATA_W(16), .ADDR_W(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_rd         (in_rd),
        .in_reg_write  (in_reg_write),
        .in_wb_sel     (in_wb_sel),
        .in_alu_result (in_alu_result),
        .in_pc_plus1   (in_pc_plus1),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .flush         (flush),
        .write_enable  (write_enable),
        .write_reg     (write_reg),
        .write_data    (write_data),
        .retire_count  (retire_count)
    );

    // Reference model: an instruction waiting on load data, and the write
    // that is presented to the register file this cycle.
    logic        m_wait;
    logic [3:0]  m_pend_rd;
    logic        m_pend_we;
    logic        m_commit;
    logic [3:0]  m_cur_rd;
    logic        m_cur_we;
    logic [15:0] m_cur_data;
    logic [3:0]  m_last_reg;
    logic [15:0] m_last_data;
    logic [15:0] m_retired;

    task automatic model_clear();
        m_wait = 0; m_pend_rd = 0; m_pend_we = 0;
        m_commit = 0; m_cur_rd = 0; m_cur_we = 0; m_cur_data = 0;
        m_last_reg = 0; m_last_data = 0; m_retired = 0;
    endtask

    task automatic model_edge();
        logic nc;
        if (reset) begin
            model_clear();
            return;
        end
        nc = 1'b0;
        if (m_commit) begin
            m_last_reg  = m_cur_rd;
            m_last_data = m_cur_data;
            m_retired   = m_retired + 16'd1;
        end
        if (m_wait) begin
            if (flush) begin
                m_wait = 0;
            end else if (mem_ack) begin
                m_wait = 0; nc = 1'b1;
                m_cur_rd = m_pend_rd; m_cur_we = m_pend_we; m_cur_data = mem_rdata;
            end
        end else if (in_valid && !flush) begin
            if (in_wb_sel == 2'b01) begin
                m_wait = 1; m_pend_rd = in_rd; m_pend_we = in_reg_write;
            end else begin
                nc = 1'b1;
                m_cur_rd = in_rd; m_cur_we = in_reg_write;
                m_cur_data = (in_wb_sel == 2'b10) ? in_pc_plus1 : in_alu_result;
            end
        end
        m_commit = nc;
    endtask

    task automatic model_expect(output logic e_we, output logic [3:0] e_reg,
                                output logic [15:0] e_data, output logic e_rdy,
                                output logic [15:0] e_cnt);
        e_we = 0; e_reg = 0; e_data = 0; e_rdy = 0; e_cnt = 0;
        if (!reset) begin
            e_we   = m_commit && m_cur_we;
            e_reg  = m_commit ? m_cur_rd : m_last_reg;
            e_data = m_commit ? m_cur_data : m_last_data;
            e_rdy  = !m_wait && !flush;
`ifdef RETIRE_CNT_EN
            e_cnt  = m_retired;
`endif
        end
    endtask

    task automatic idle_inputs();
        reset = 0; in_valid = 0; in_rd = 0; in_reg_write = 0; in_wb_sel = 0;
        in_alu_result = 0; in_pc_plus1 = 0; mem_ack = 0; mem_rdata = 0; flush = 0;
    endtask

    task automatic offer(input logic [3:0] rd, input logic rw, input logic [1:0] sel,
                         input logic [15:0] alu, input logic [15:0] pc);
        in_valid = 1; in_rd = rd; in_reg_write = rw; in_wb_sel = sel;
        in_alu_result = alu; in_pc_plus1 = pc;
    endtask

    // Inputs are applied just after a falling edge; outputs are read 1ns later.
    task automatic advance();
        model_edge();
        @(negedge clk);
        idle_inputs();
        #1;
    endtask

    task automatic test_reset();
        reset = 1; in_valid = 1; in_wb_sel = 2'b00; in_reg_write = 1; in_alu_result = 16'h1234;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({write_enable, write_reg, write_data, in_ready, retire_count} !== 38'd0) begin
                failures++;
                $display("FAIL reset_outputs cyc=%0d got we=%b reg=%0d data=%h rdy=%b cnt=%h want all zero",
                         i, write_enable, write_reg, write_data, in_ready, retire_count);
            end
            model_edge();
            @(negedge clk);
            reset = 1; #1;
        end
        advance();
        checks++;
        if (write_enable !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release got we=%b rdy=%b want we=0 rdy=1", write_enable, in_ready);
        end
    endtask

    task automatic test_alu_write();
        offer(4'd1, 1'b1, 2'b00, 16'h00A5, 16'h0000);
        #1;
        advance();
        checks++;
        if (write_enable !== 1'b1 || write_reg !== 4'd1 || write_data !== 16'h00A5) begin
            failures++;
            $display("FAIL alu_write got we=%b reg=%0d data=%h want we=1 reg=1 data=00a5",
                     write_enable, write_reg, write_data);
        end
        advance();
        checks++;
        if (write_enable !== 1'b0 || write_reg !== 4'd1 || write_data !== 16'h00A5) begin
            failures++;
            $display("FAIL alu_hold got we=%b reg=%0d data=%h want we=0 reg=1 data=00a5",
                     write_enable, write_reg, write_data);
        end
    endtask

    task automatic test_load();
        offer(4'd3, 1'b1, 2'b01, 16'h1111, 16'h2222);
        #1;
        advance();
        for (int i = 0; i < 3; i++) begin
            mem_ack = 0; mem_rdata = 16'hDEAD; #1;
            checks++;
            if (in_ready !== 1'b0 || write_enable !== 1'b0) begin
                failures++;
                $display("FAIL load_wait cyc=%0d got rdy=%b we=%b want rdy=0 we=0", i, in_ready, write_enable);
            end
            advance();
        end
        mem_ack = 1; mem_rdata = 16'hBEEF; #1;
        advance();
        checks++;
        if (write_enable !== 1'b1 || write_reg !== 4'd3 || write_data !== 16'hBEEF || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL load_commit got we=%b reg=%0d data=%h rdy=%b want we=1 reg=3 data=beef rdy=1",
                     write_enable, write_reg, write_data, in_ready);
        end
        advance();
    endtask

    task automatic test_back_to_back();
        offer(4'd2, 1'b1, 2'b00, 16'h0011, 16'h0000);
        #1;
        advance();
        offer(4'd4, 1'b1, 2'b11, 16'h0022, 16'h7777);
        #1;
        checks++;
        if (write_enable !== 1'b1 || write_reg !== 4'd2 || write_data !== 16'h0011 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_first got we=%b reg=%0d data=%h rdy=%b want we=1 reg=2 data=0011 rdy=1",
                     write_enable, write_reg, write_data, in_ready);
        end
        advance();
        checks++;
        if (write_enable !== 1'b1 || write_reg !== 4'd4 || write_data !== 16'h0022) begin
            failures++;
            $display("FAIL b2b_second got we=%b reg=%0d data=%h want we=1 reg=4 data=0022",
                     write_enable, write_reg, write_data);
        end
        offer(4'd0, 1'b1, 2'b10, 16'h0001, 16'h0042);
        #1;
        advance();
        checks++;
        if (write_enable !== 1'b1 || write_reg !== 4'd0 || write_data !== 16'h0042) begin
            failures++;
            $display("FAIL pc_to_r0 got we=%b reg=%0d data=%h want we=1 reg=0 data=0042",
                     write_enable, write_reg, write_data);
        end
        advance();
    endtask

    task automatic test_flush();
        offer(4'd5, 1'b1, 2'b01, 16'h0000, 16'h0000);
        #1;
        advance();
        flush = 1; mem_ack = 1; mem_rdata = 16'hCAFE; #1;
        checks++;
        if (write_enable !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL flush_ack_same got we=%b rdy=%b want we=0 rdy=0", write_enable, in_ready);
        end
        advance();
        checks++;
        if (write_enable !== 1'b0 || in_ready !== 1'b1 || write_reg !== 4'd0 || write_data !== 16'h0042) begin
            failures++;
            $display("FAIL flush_ack_after got we=%b rdy=%b reg=%0d data=%h want we=0 rdy=1 reg=0 data=0042",
                     write_enable, in_ready, write_reg, write_data);
        end
        offer(4'd6, 1'b0, 2'b00, 16'h0066, 16'h0000);
        #1;
        advance();
        offer(4'd7, 1'b1, 2'b00, 16'h0077, 16'h0000);
        flush = 1; #1;
        checks++;
        if (write_reg !== 4'd6 || write_data !== 16'h0066 || write_enable !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL flush_commit got we=%b reg=%0d data=%h rdy=%b want we=0 reg=6 data=0066 rdy=0",
                     write_enable, write_reg, write_data, in_ready);
        end
        advance();
        checks++;
        if (write_enable !== 1'b0 || write_reg !== 4'd6) begin
            failures++;
            $display("FAIL flush_blocks_accept got we=%b reg=%0d want we=0 reg=6", write_enable, write_reg);
        end
    endtask

    task automatic test_midop_reset();
        offer(4'd9, 1'b1, 2'b01, 16'h0000, 16'h0000);
        #1;
        advance();
        reset = 1; #1;
        checks++;
        if ({write_enable, write_reg, write_data, in_ready, retire_count} !== 38'd0) begin
            failures++;
            $display("FAIL reset_in_wait got we=%b reg=%0d data=%h rdy=%b cnt=%h want all zero",
                     write_enable, write_reg, write_data, in_ready, retire_count);
        end
        advance();
        mem_ack = 1; mem_rdata = 16'h5555; #1;
        checks++;
        if (write_enable !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL ack_after_reset got we=%b rdy=%b want we=0 rdy=1", write_enable, in_ready);
        end
        advance();
        checks++;
        if (write_enable !== 1'b0) begin
            failures++;
            $display("FAIL no_write_after_reset got we=%b want 0", write_enable);
        end
        offer(4'd10, 1'b1, 2'b00, 16'hAAAA, 16'h0000);
        #1;
        advance();
        reset = 1; #1;
        checks++;
        if (write_enable !== 1'b0 || write_data !== 16'h0000) begin
            failures++;
            $display("FAIL reset_in_commit got we=%b data=%h want we=0 data=0000", write_enable, write_data);
        end
        advance();
    endtask

    task automatic test_random();
        logic        e_we, e_rdy;
        logic [3:0]  e_reg;
        logic [15:0] e_data, e_cnt;
        for (int c = 0; c < 600; c++) begin
            reset         = ($urandom_range(0, 63) == 0);
            in_valid      = ($urandom_range(0, 3) != 0);
            in_rd         = 4'($urandom);
            in_reg_write  = ($urandom_range(0, 4) != 0);
            in_wb_sel     = 2'($urandom);
            in_alu_result = 16'($urandom);
            in_pc_plus1   = 16'($urandom);
            mem_ack       = ($urandom_range(0, 2) == 0);
            mem_rdata     = 16'($urandom);
            flush         = ($urandom_range(0, 7) == 0);
            #1;
            model_expect(e_we, e_reg, e_data, e_rdy, e_cnt);
            checks++;
            if (write_enable !== e_we) begin
                failures++;
                $display("FAIL rand_we cyc=%0d got=%b want=%b", c, write_enable, e_we);
            end
            checks++;
            if (write_reg !== e_reg) begin
                failures++;
                $display("FAIL rand_reg cyc=%0d got=%0d want=%0d", c, write_reg, e_reg);
            end
            checks++;
            if (write_data !== e_data) begin
                failures++;
                $display("FAIL rand_data cyc=%0d got=%h want=%h", c, write_data, e_data);
            end
            checks++;
            if (in_ready !== e_rdy) begin
                failures++;
                $display("FAIL rand_ready cyc=%0d got=%b want=%b", c, in_ready, e_rdy);
            end
            checks++;
            if (retire_count !== e_cnt) begin
                failures++;
                $display("FAIL rand_retire cyc=%0d got=%h want=%h", c, retire_count, e_cnt);
            end
            advance();
        end
    endtask

`ifdef RETIRE_CNT_EN
    task automatic test_retire_wrap();
        reset = 1; #1;
        advance();
        for (int i = 0; i < 65536; i++) begin
            offer(4'($urandom), 1'($urandom), 2'b00, 16'($urandom), 16'h0000);
            #1;
            advance();
        end
        checks++;
        if (retire_count !== 16'hFFFF || write_enable === 1'bx) begin
            failures++;
            $display("FAIL retire_before_wrap got=%h want=ffff", retire_count);
        end
        advance();
        checks++;
        if (retire_count !== 16'h0000) begin
            failures++;
            $display("FAIL retire_wrap got=%h want=0000", retire_count);
        end
    endtask
`endif

    initial begin
        idle_inputs();
        model_clear();
        reset = 1;
        @(negedge clk);
        test_reset();
        test_alu_write();
        test_load();
        test_back_to_back();
        test_flush();
        test_midop_reset();
        test_random();
`ifdef RETIRE_CNT_EN
        test_retire_wrap();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
